apb_cmd_sequencer: RTL

Upstream feeder for the APB master. Accepts read/write commands over a valid/ready interface and buffers them in a FIFO. Drives the master's PSEL/transfer/PWRITE/PADDR/PDATA one transfer at a time, then returns completion status and read data. Replaces hand-sequenced PSEL toggling with a queued, back-to-back-safe command stream.

---
 rtl/apb_cmd_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/apb_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_sequencer
// Purpose  : Queues APB read/write commands in a small FIFO and sequences them
//            one at a time onto the APB master interface
//            (IDLE -> SETUP -> ACCESS), then returns a one-cycle completion
//            pulse carrying status and read data.
// Options  : define APB_SEQ_TIMEOUT_EN to abort ACCESS after TIMEOUT cycles
//            without PREADY. The abort is reported with rsp_err=1.
// Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                       PCLK,
  input  logic                       PRESET,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_W-1:0]          cmd_addr,
  input  logic [DATA_W-1:0]          cmd_data,
  output logic                       PSEL,
  output logic                       transfer,
  output logic                       PWRITE,
  output logic [ADDR_W-1:0]          PADDR,
  output logic [DATA_W-1:0]          PDATA,
  input  logic                       PREADY,
  input  logic [DATA_W-1:0]          PRDATA,
  output logic                       rsp_valid,
  output logic                       rsp_write,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state;
  logic               fifo_write [DEPTH];
  logic [ADDR_W-1:0]  fifo_addr  [DEPTH];
  logic [DATA_W-1:0]  fifo_data  [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;

  // No bypass: a command must land in the FIFO before IDLE can pop it.
  assign cmd_ready = (count != CNT_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);
  assign busy      = (state != IDLE) || (count != '0);

  // Command storage; contents need no reset because the pointers gate reads.
  always_ff @(posedge PCLK) begin
    if (push) begin
      fifo_write[wr_ptr] <= cmd_write;
      fifo_addr[wr_ptr]  <= cmd_addr;
      fifo_data[wr_ptr]  <= cmd_data;
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)
        count <= count + CNT_W'(1);
      else if (!push && pop)
        count <= count - CNT_W'(1);
    end
  end

`ifdef APB_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0] wait_cnt;
  logic            err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Transfer sequencer with registered APB and response outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      PSEL      <= 1'b0;
      transfer  <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PDATA     <= '0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_data  <= '0;
`ifdef APB_SEQ_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            PWRITE   <= fifo_write[rd_ptr];
            PADDR    <= fifo_addr[rd_ptr];
            PDATA    <= fifo_data[rd_ptr];
            PSEL     <= 1'b1;
            transfer <= 1'b1;
            state    <= SETUP;
          end else begin
            PSEL     <= 1'b0;
            transfer <= 1'b0;
          end
        end
        SETUP: begin
          state <= ACCESS;
`ifdef APB_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_valid <= 1'b1;
            rsp_write <= PWRITE;
            rsp_data  <= PWRITE ? '0 : PRDATA;
            PSEL      <= 1'b0;
            transfer  <= 1'b0;
            state     <= IDLE;
`ifdef APB_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (wait_cnt == TO_W'(TIMEOUT-1)) begin
            // Expiry without PREADY: abandon the transfer and flag it.
            rsp_valid <= 1'b1;
            rsp_write <= PWRITE;
            rsp_data  <= '0;
            err_q     <= 1'b1;
            PSEL      <= 1'b0;
            transfer  <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt  <= wait_cnt + TO_W'(1);
`endif
          end
        end
        default: begin
          PSEL     <= 1'b0;
          transfer <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
